fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the core: PC, writable jump-target LUT, instruction register, req/done run control.
//  Replaces the fixed-width PC + hardwired PC_LUT pair; adds stall, taken-branch flush, relative offsets, halt FSM, cycle counter.
//  Sits between instruction ROM (combinational read) and the control decoder / register file.
// PARAMETERS
//  D        12   program counter width
//  IW       9    instruction (machine code) width
//  LUT_N    4    jump-target LUT entries (power of 2, >=2)
//  START_PC 0    PC loaded on run start
//  HALT_PC  128  PC value that terminates a run
//  CW       16   cycle counter width
// PORTS
//  clk          in   1              clock, rising edge
//  reset        in   1              asynchronous, active-low reset
//  req          in   1              run request (level)
//  done         out  1              run finished; held in HALT
//  busy         out  1              state == RUN
//  stall        in   1              hold PC and instruction register
//  absjump_en   in   1              taken jump to LUT target
//  reljump_en   in   1              taken jump PC-relative
//  lut_sel      in   $clog2(LUT_N)  LUT entry for absolute jump
//  rel_off      in   8              signed offset for relative jump
//  lut_wr_en    in   1              LUT write strobe
//  lut_wr_addr  in   $clog2(LUT_N)  LUT write index
//  lut_wr_data  in   D              LUT write value
//  imem_addr    out  D              ROM address (= current PC)
//  imem_data    in   IW             ROM data for imem_addr
//  instr_out    out  IW             registered instruction to decoder
//  instr_valid  out  1              instr_out valid this cycle
//  pc_out       out  D              PC of instr_out
//  cycle_cnt    out  CW             RUN cycles in current/last run
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE, PC=START_PC, instr_out=0, instr_valid=0, pc_out=0, done=0, cycle_cnt=0, LUT all 0.
//  FSM: IDLE --req=1--> RUN (PC<=START_PC, cycle_cnt<=0). RUN --PC==HALT_PC--> HALT. HALT --req=0--> IDLE.
//   HALT with req held 1 stays HALT; a new run needs req to drop then rise.
//  done=1 iff state HALT (registered); busy=1 iff state RUN.
//  RUN, stall=0, no jump: instr_out<=imem_data, pc_out<=PC, instr_valid<=1, PC<=PC+1 (mod 2^D).
//  Latency: ROM word at PC appears on instr_out one cycle after PC presented.
//  Jumps qualify only when instr_valid=1 (decoder acts on instr_out):
//   abs: PC<=LUT[lut_sel]; rel: PC<=pc_out+sign_ext(rel_off) (mod 2^D).
//   Taken jump flushes the sequential fetch: instr_valid<=0 for one cycle (1-cycle bubble).
//   abs and rel both asserted: abs wins. Jump inputs ignored when instr_valid=0 or state!=RUN.
//  stall=1 in RUN: PC, instr_out, instr_valid, pc_out hold; jumps ignored (decoder re-presents); cycle_cnt still counts.
//  Halt check uses current PC before fetch: PC==HALT_PC -> no fetch, instr_valid<=0, go HALT. Jump target == HALT_PC halts next cycle.
//  IDLE/HALT: instr_valid=0, PC holds.
//  cycle_cnt: +1 per RUN cycle, saturates at 2^CW-1, holds in HALT/IDLE.
//  LUT: write at clock edge in any state; read async; same-cycle write+read of one entry returns old value.
//  imem_addr = PC combinationally.
// STRUCTURE
//  fetch_pkg: fetch_state_t enum {IDLE,RUN,HALT}; default parameter constants.
//  Sub-module jump_lut: LUT_N x D register array, 1 sync write port, 1 async read port, async active-low clear.
// TESTING
//  Reset mid-RUN at PC=37 -> all outputs to reset values next sample; IDLE; LUT reads 0.
//  req=1, ROM[i]=i, no jumps -> instr_valid from cycle 2; pc_out 0,1,2..127; done=1 when PC=128; cycle_cnt=129.
//  LUT[2]=12'h040 written, absjump_en+lut_sel=2 on pc_out=5 -> one invalid cycle, then pc_out=0x040.
//  reljump_en, rel_off=-3 at pc_out=10 -> bubble, then pc_out=7; abs+rel together -> LUT target taken.
//  stall 3 cycles at pc_out=20 with absjump_en high -> instr_out/pc_out frozen, no jump; resumes at pc_out=21.
//  done held while req=1; req=0 -> IDLE, done=0; req=1 again -> restart at START_PC, cycle_cnt cleared.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default parameter values for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int DEF_D        = 12;
    localparam int DEF_IW       = 9;
    localparam int DEF_LUT_N    = 4;
    localparam int DEF_START_PC = 0;
    localparam int DEF_HALT_PC  = 128;
    localparam int DEF_CW       = 16;
    localparam int REL_W        = 8;

endpackage

// File: rtl/fetch_unit_jump_lut.sv
// Writable jump-target table: one synchronous write port, one asynchronous read port.
// A write and a read of the same entry in one cycle returns the pre-write value.
module jump_lut #(
    parameter int LUT_N = 4,
    parameter int D     = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [$clog2(LUT_N)-1:0] wr_addr_i,
    input  logic [D-1:0]             wr_data_i,
    input  logic [$clog2(LUT_N)-1:0] rd_addr_i,
    output logic [D-1:0]             rd_data_o
);

    logic [D-1:0] mem_q [LUT_N];

    // Table storage with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LUT_N; i++) begin
                mem_q[i] <= {D{1'b0}};
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, jump-target LUT, instruction register and
// IDLE/RUN/HALT run control between the instruction ROM and the decoder.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int D        = DEF_D,
    parameter int IW       = DEF_IW,
    parameter int LUT_N    = DEF_LUT_N,
    parameter int START_PC = DEF_START_PC,
    parameter int HALT_PC  = DEF_HALT_PC,
    parameter int CW       = DEF_CW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    output logic                     done,
    output logic                     busy,
    input  logic                     stall,
    input  logic                     absjump_en,
    input  logic                     reljump_en,
    input  logic [$clog2(LUT_N)-1:0] lut_sel,
    input  logic [REL_W-1:0]         rel_off,
    input  logic                     lut_wr_en,
    input  logic [$clog2(LUT_N)-1:0] lut_wr_addr,
    input  logic [D-1:0]             lut_wr_data,
    output logic [D-1:0]             imem_addr,
    input  logic [IW-1:0]            imem_data,
    output logic [IW-1:0]            instr_out,
    output logic                     instr_valid,
    output logic [D-1:0]             pc_out,
    output logic [CW-1:0]            cycle_cnt
);

    localparam logic [D-1:0]  START_A = D'(START_PC);
    localparam logic [D-1:0]  HALT_A  = D'(HALT_PC);
    localparam logic [D-1:0]  PC_ONE  = D'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    function automatic logic [D-1:0] sext_off(input logic [REL_W-1:0] off);
        return {{(D-REL_W){off[REL_W-1]}}, off};
    endfunction

    fetch_state_t   state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic [IW-1:0]  instr_q, instr_d;
    logic           valid_q, valid_d;
    logic [D-1:0]   pcout_q, pcout_d;
    logic           done_q, done_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [D-1:0]   lut_rd_s;
    logic           jump_s;
    logic [D-1:0]   target_s;

    jump_lut #(
        .LUT_N (LUT_N),
        .D     (D)
    ) u_jump_lut (
        .clk_i     (clk),
        .rst_ni    (reset),
        .wr_en_i   (lut_wr_en),
        .wr_addr_i (lut_wr_addr),
        .wr_data_i (lut_wr_data),
        .rd_addr_i (lut_sel),
        .rd_data_o (lut_rd_s)
    );

    // Jumps act on the instruction currently held for the decoder; absolute wins over relative.
    always_comb begin
        jump_s = valid_q & (absjump_en | reljump_en);
        if (absjump_en) begin
            target_s = lut_rd_s;
        end else begin
            target_s = pcout_q + sext_off(rel_off);
        end
    end

    // Next-state logic for run control, PC and the instruction register.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pcout_d = pcout_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                done_d  = 1'b0;
                if (req) begin
                    state_d = RUN;
                    pc_d    = START_A;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
                if (stall) begin
                    pc_d = pc_q;
                end else if (jump_s) begin
                    // The word fetched this cycle is on the wrong path: drop it.
                    pc_d    = target_s;
                    valid_d = 1'b0;
                end else if (pc_q == HALT_A) begin
                    valid_d = 1'b0;
                    state_d = HALT;
                    done_d  = 1'b1;
                end else begin
                    instr_d = imem_data;
                    pcout_d = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_ONE;
                end
            end
            HALT: begin
                valid_d = 1'b0;
                if (!req) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else begin
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= START_A;
            instr_q <= {IW{1'b0}};
            valid_q <= 1'b0;
            pcout_q <= {D{1'b0}};
            done_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pcout_q <= pcout_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pcout_q;
    assign done        = done_q;
    assign busy        = (state_q == RUN);
    assign cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an identity ROM (ROM[i] = i).
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        req;
    logic        done;
    logic        busy;
    logic        stall;
    logic        absjump_en;
    logic        reljump_en;
    logic [1:0]  lut_sel;
    logic [7:0]  rel_off;
    logic        lut_wr_en;
    logic [1:0]  lut_wr_addr;
    logic [11:0] lut_wr_data;
    logic [11:0] imem_addr;
    logic [8:0]  imem_data;
    logic [8:0]  instr_out;
    logic        instr_valid;
    logic [11:0] pc_out;
    logic [15:0] cycle_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .busy        (busy),
        .stall       (stall),
        .absjump_en  (absjump_en),
        .reljump_en  (reljump_en),
        .lut_sel     (lut_sel),
        .rel_off     (rel_off),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_addr (lut_wr_addr),
        .lut_wr_data (lut_wr_data),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .cycle_cnt   (cycle_cnt)
    );

    assign imem_data = imem_addr[8:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        stall;
        logic        abs_en;
        logic        rel_en;
        logic [1:0]  sel;
        logic [7:0]  off;
        logic        e_valid;
        logic [11:0] e_pc;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic r, input logic s, input logic a, input logic rl,
                           input logic [1:0] sl, input logic [7:0] o, input logic ev, input logic [11:0] ep);
        vecs[i].req = r;     vecs[i].stall = s;  vecs[i].abs_en = a; vecs[i].rel_en = rl;
        vecs[i].sel = sl;    vecs[i].off = o;    vecs[i].e_valid = ev; vecs[i].e_pc = ep;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; absjump_en = 1'b0; reljump_en = 1'b0;
        lut_sel = 2'd0; rel_off = 8'd0; lut_wr_en = 1'b0;
        lut_wr_addr = 2'd0; lut_wr_data = 12'd0;
    endtask

    initial begin
        // Jump/stall vectors; each row drives one clock, then outputs are checked.
        set_vec(0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 12'd127);
        for (int k = 1; k <= 11; k++) begin
            set_vec(k, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 12'(k - 1));
        end
        set_vec(12, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'hFD, 1'b0, 12'd10);
        set_vec(13, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 12'd7);
        set_vec(14, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 12'd8);
        set_vec(15, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'hFB, 1'b0, 12'd8);
        set_vec(16, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 12'd3);
        set_vec(17, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 12'd4);
        set_vec(18, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 12'd5);
        set_vec(19, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 12'd5);
        set_vec(20, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 12'h040);
        set_vec(21, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 12'h041);
        set_vec(22, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 8'h02, 1'b0, 12'h041);
        set_vec(23, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 12'h040);
        set_vec(24, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'hD4, 1'b0, 12'h040);
        set_vec(25, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 12'd20);
        set_vec(26, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 12'd20);
        set_vec(27, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 12'd20);
        set_vec(28, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 12'd20);
        set_vec(29, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 12'd21);
        set_vec(30, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 12'd22);

        reset = 1'b0;
        req = 1'b0;
        idle_inputs();
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_instr", 32'(instr_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(cycle_cnt), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        #2 reset = 1'b1;

        lut_wr_en = 1'b1; lut_wr_addr = 2'd2; lut_wr_data = 12'h040;
        tick();
        idle_inputs();
        check("idle_no_run", 32'(busy), 32'd0);

        // Straight-line run from START_PC to HALT_PC.
        req = 1'b1;
        tick();
        check("run_busy", 32'(busy), 32'd1);
        check("run_first_valid", 32'(instr_valid), 32'd0);
        for (int k = 1; k <= 128; k++) begin
            tick();
            check("seq_valid", 32'(instr_valid), 32'd1);
            check("seq_pc_out", 32'(pc_out), 32'(k - 1));
            check("seq_instr", 32'(instr_out), 32'(k - 1));
        end
        tick();
        check("halt_done", 32'(done), 32'd1);
        check("halt_valid", 32'(instr_valid), 32'd0);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_cnt", 32'(cycle_cnt), 32'd129);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("halt_hold_done", 32'(done), 32'd1);
            check("halt_hold_cnt", 32'(cycle_cnt), 32'd129);
        end
        req = 1'b0;
        tick();
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Restarted run driven from the vector table.
        for (int i = 0; i < NVEC; i++) begin
            req = vecs[i].req; stall = vecs[i].stall;
            absjump_en = vecs[i].abs_en; reljump_en = vecs[i].rel_en;
            lut_sel = vecs[i].sel; rel_off = vecs[i].off;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_pc_out", i), 32'(pc_out), 32'(vecs[i].e_pc));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_instr", i), 32'(instr_out), 32'(vecs[i].e_pc[8:0]));
            end
            if (i == 0) begin
                check("restart_cnt", 32'(cycle_cnt), 32'd0);
                check("restart_addr", 32'(imem_addr), 32'd0);
            end
        end
        idle_inputs();
        check("table_cnt", 32'(cycle_cnt), 32'd30);
        check("table_addr", 32'(imem_addr), 32'd23);

        // Asynchronous reset in the middle of a run.
        for (int k = 0; k < 14; k++) begin
            tick();
        end
        check("pre_reset_addr", 32'(imem_addr), 32'd37);
        reset = 1'b0;
        req = 1'b0;
        #1;
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_pc_out", 32'(pc_out), 32'd0);
        check("mid_rst_instr", 32'(instr_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cnt", 32'(cycle_cnt), 32'd0);
        check("mid_rst_addr", 32'(imem_addr), 32'd0);
        #1 reset = 1'b1;

        // LUT cleared by reset; write-during-read returns the old entry; jump onto HALT_PC.
        req = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_pc_out", 32'(pc_out), 32'd1);
        absjump_en = 1'b1; lut_sel = 2'd2;
        lut_wr_en = 1'b1; lut_wr_addr = 2'd2; lut_wr_data = 12'h050;
        tick();
        idle_inputs();
        check("lut_bubble", 32'(instr_valid), 32'd0);
        tick();
        check("lut_cleared_pc", 32'(pc_out), 32'd0);
        absjump_en = 1'b1; lut_sel = 2'd2;
        lut_wr_en = 1'b1; lut_wr_addr = 2'd1; lut_wr_data = 12'h080;
        tick();
        idle_inputs();
        tick();
        check("lut_new_pc", 32'(pc_out), 32'h050);
        absjump_en = 1'b1; lut_sel = 2'd1;
        tick();
        idle_inputs();
        check("jump_halt_not_yet", 32'(done), 32'd0);
        check("jump_halt_addr", 32'(imem_addr), 32'h080);
        tick();
        check("jump_halt_done", 32'(done), 32'd1);
        check("jump_halt_valid", 32'(instr_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
